// File: rtl/dcpu_intc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dcpu_intc_pkg                                          |
// | Description : Shared constants for the dcpu interrupt controller:    |
// |               register offsets, VECTOR layout and source limits.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dcpu_intc_pkg;

   // Word offsets within the controller's register window
   localparam logic [2:0] REG_PENDING = 3'd0;
   localparam logic [2:0] REG_ENABLE  = 3'd1;
   localparam logic [2:0] REG_VECTOR  = 3'd2;
   localparam logic [2:0] REG_SWSET   = 3'd3;
   localparam logic [2:0] REG_MODE    = 3'd4;

   // Bit of the VECTOR read word that flags a valid source index
   localparam int VECTOR_VALID_BIT = 15;

   // Largest supported source count; the index field is sized to cover it
   localparam int NSRC_MAX = 15;
   localparam int IDX_W    = $clog2(NSRC_MAX + 1);

endpackage : dcpu_intc_pkg
`default_nettype wire

// File: rtl/dcpu_intc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dcpu_intc_if                                           |
// | Description : CPU data-bus slice seen by the interrupt controller    |
// |               (chip select, word offset, direction, data both ways). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface dcpu_intc_if;

   logic        i_cs;
   logic [2:0]  i_addr;
   logic        i_rw;
   logic [15:0] i_dat;
   logic [15:0] o_dat;

   // CPU / decoder side
   modport master (
      output i_cs,
      output i_addr,
      output i_rw,
      output i_dat,
      input  o_dat
   );

   // Controller side
   modport slave (
      input  i_cs,
      input  i_addr,
      input  i_rw,
      input  i_dat,
      output o_dat
   );

endinterface : dcpu_intc_if
`default_nettype wire

// File: rtl/dcpu_intc_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dcpu_intc_prio                                         |
// | Description : Combinational priority encoder; the lowest set request |
// |               bit wins. valid flags that any request is present.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dcpu_intc_prio
   import dcpu_intc_pkg::*;
#(
   parameter int NSRC = 8
)
(
   input  logic [NSRC-1:0]  req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top down so the lowest set index is the last one written
   always_comb begin
      idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign valid = |req;

endmodule : dcpu_intc_prio
`default_nettype wire

// File: rtl/dcpu_intc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dcpu_intc                                              |
// | Description : Memory-mapped interrupt controller for the dcpu.       |
// |               Edge-detects NSRC sources into a pending register,     |
// |               masks with ENABLE and drives a registered o_int. The   |
// |               ISR reads VECTOR to get and acknowledge the winner.    |
// |               Optional macro DCPU_INTC_LEVEL_EN adds the MODE        |
// |               register for per-source level-sensitive operation.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dcpu_intc
   import dcpu_intc_pkg::*;
#(
   parameter int NSRC = 8
)
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [NSRC-1:0] i_src,
   dcpu_intc_if.slave      bus,
   output logic            o_int
);

   logic [NSRC-1:0]  pending;
   logic [NSRC-1:0]  enable;
   logic [NSRC-1:0]  prev;

   logic [NSRC-1:0]  pending_next;
   logic [NSRC-1:0]  enable_next;
   logic [NSRC-1:0]  edge_next;
   logic [NSRC-1:0]  req;
   logic [NSRC-1:0]  rise;
   logic [NSRC-1:0]  w1c;
   logic [NSRC-1:0]  ack;
   logic [NSRC-1:0]  swset;
   logic [NSRC-1:0]  wdat;
   logic [IDX_W-1:0] idx;
   logic             valid;
   logic             rd;
   logic             wr;
   logic [15:0]      rdata;

   // Bits of the write word above the source field carry no meaning here
   logic             unused_dat;
   assign unused_dat = &{1'b0, bus.i_dat[15:NSRC]};

   assign rd   = bus.i_cs &  bus.i_rw;
   assign wr   = bus.i_cs & ~bus.i_rw;
   assign wdat = bus.i_dat[NSRC-1:0];
   assign req  = pending & enable;

   dcpu_intc_prio #(
      .NSRC (NSRC)
   ) u_prio (
      .req   (req),
      .idx   (idx),
      .valid (valid)
   );

`ifdef DCPU_INTC_LEVEL_EN
   logic [NSRC-1:0] mode;

   // Per-source level/edge select, written through the MODE register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mode <= '0;
      end else if (wr && bus.i_addr == REG_MODE) begin
         mode <= wdat;
      end
   end
`endif

   // Decode bus side effects and form next pending/enable state
   always_comb begin
      rise        = i_src & ~prev;
      w1c         = (wr && bus.i_addr == REG_PENDING) ? wdat : '0;
      swset       = (wr && bus.i_addr == REG_SWSET)   ? wdat : '0;
      enable_next = (wr && bus.i_addr == REG_ENABLE)  ? wdat : enable;
      for (int i = 0; i < NSRC; i++) begin
         ack[i] = rd && (bus.i_addr == REG_VECTOR) && valid && (idx == IDX_W'(i));
      end
      // Sets are OR-ed in after clears so a coincident event is never lost
      edge_next = (pending & ~(w1c | ack)) | rise | swset;
`ifdef DCPU_INTC_LEVEL_EN
      // Level sources simply follow the input, with SWSET still able to pulse them
      pending_next = (edge_next & ~mode) | ((i_src | swset) & mode);
`else
      pending_next = edge_next;
`endif
   end

   // State update; prev tracks the inputs through reset so held-high sources stay quiet
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pending <= '0;
         enable  <= '0;
         prev    <= i_src;
         o_int   <= 1'b0;
      end else begin
         pending <= pending_next;
         enable  <= enable_next;
         prev    <= i_src;
         o_int   <= |(pending_next & enable_next);
      end
   end

   // Combinational read mux so reads complete within the access cycle
   always_comb begin
      rdata = '0;
      if (bus.i_cs) begin
         case (bus.i_addr)
            REG_PENDING: rdata[NSRC-1:0] = pending;
            REG_ENABLE:  rdata[NSRC-1:0] = enable;
            REG_VECTOR: begin
               if (valid) begin
                  rdata[VECTOR_VALID_BIT] = 1'b1;
                  rdata[IDX_W-1:0]        = idx;
               end
            end
`ifdef DCPU_INTC_LEVEL_EN
            REG_MODE:    rdata[NSRC-1:0] = mode;
`else
            REG_MODE:    rdata = '0;
`endif
            default:     rdata = '0;
         endcase
      end
   end

   assign bus.o_dat = rdata;

endmodule : dcpu_intc
`default_nettype wire

// File: tb/tb_dcpu_intc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dcpu_intc                                           |
// | Description : Self-checking bench for dcpu_intc: directed scenarios  |
// |               followed by random bus traffic, all checked against a  |
// |               behavioural model of the register/interrupt rules.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dcpu_intc;

   logic       clk = 1'b0;
   logic       i_reset;
   logic [7:0] src;
   logic       o_int;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [7:0]  m_pend, m_en, m_prev, m_mode;
   logic        m_int;
   logic        m_init = 1'b0;
   logic [15:0] last_dat;
   logic [7:0]  cur_src;

   dcpu_intc_if bus ();

   dcpu_intc #(
      .NSRC (8)
   ) dut (
      .i_clk   (clk),
      .i_reset (i_reset),
      .i_src   (src),
      .bus     (bus),
      .o_int   (o_int)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // What the bus should return for a given offset in the current model state
   function automatic logic [15:0] m_read(input logic cs, input logic [2:0] a);
      int w;
      if (!cs) return 16'h0000;
      case (a)
         3'd0: return {8'h00, m_pend};
         3'd1: return {8'h00, m_en};
         3'd2: begin
            w = lowest(m_pend & m_en);
            if (w < 0) return 16'h0000;
            return 16'h8000 | 16'(w);
         end
`ifdef DCPU_INTC_LEVEL_EN
         3'd4: return {8'h00, m_mode};
`endif
         default: return 16'h0000;
      endcase
   endfunction

   // Advance the model across one clock edge
   task automatic m_edge(input logic r, input logic cs, input logic [2:0] a,
                         input logic rw, input logic [15:0] d, input logic [7:0] s);
      logic [7:0] setb, clr, sw, npend;
      int w;
      if (r) begin
         m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_int = 1'b0;
         m_prev = s; m_init = 1'b1;
         return;
      end
      sw   = (cs && !rw && a == 3'd3) ? d[7:0] : 8'h00;
      clr  = (cs && !rw && a == 3'd0) ? d[7:0] : 8'h00;
      setb = (s & ~m_prev) | sw;
      if (cs && rw && a == 3'd2) begin
         w = lowest(m_pend & m_en);
         if (w >= 0) clr[w] = 1'b1;
      end
      npend = (m_pend & ~clr) | setb;
`ifdef DCPU_INTC_LEVEL_EN
      for (int i = 0; i < 8; i++) begin
         if (m_mode[i]) npend[i] = s[i] | sw[i];
      end
      if (cs && !rw && a == 3'd4) m_mode = d[7:0];
`endif
      m_pend = npend;
      if (cs && !rw && a == 3'd1) m_en = d[7:0];
      m_prev = s;
      m_int  = |(m_pend & m_en);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check read data before the edge, check o_int after it
   task automatic cyc(input string tag, input logic r, input logic cs, input logic [2:0] a,
                      input logic rw, input logic [15:0] d, input logic [7:0] s);
      i_reset    = r;
      src        = s;
      cur_src    = s;
      bus.i_cs   = cs;
      bus.i_addr = a;
      bus.i_rw   = rw;
      bus.i_dat  = d;
      #1;
      last_dat = bus.o_dat;
      if (m_init) chk({tag, ":dat"}, bus.o_dat, m_read(cs, a));
      @(posedge clk);
      m_edge(r, cs, a, rw, d, s);
      #1;
      chk({tag, ":int"}, {15'b0, o_int}, {15'b0, m_int});
   endtask

   task automatic wr(input string tag, input logic [2:0] a, input logic [15:0] d,
                     input logic [7:0] s);
      cyc(tag, 1'b0, 1'b1, a, 1'b0, d, s);
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] s);
      cyc(tag, 1'b0, 1'b1, a, 1'b1, 16'h0000, s);
   endtask

   initial begin
      logic       r, cs, rw;
      logic [2:0] a;
      logic [15:0] d;
      logic [7:0] s;

      // Plan 1: source held high through reset must not trigger
      cyc("rst0", 1'b1, 1'b0, 3'd0, 1'b1, 16'h0, 8'h01);
      cyc("rst1", 1'b1, 1'b0, 3'd0, 1'b1, 16'h0, 8'h01);
      wr("p1_en", 3'd1, 16'h0001, 8'h01);
      rd("p1_pend", 3'd0, 8'h01);
      chk("p1_pend_const", last_dat, 16'h0000);
      chk("p1_int_const", {15'b0, o_int}, 16'h0000);

      // Plan 2: two rises, prioritised vector reads with acknowledge
      wr("p2_en", 3'd1, 16'h000A, 8'h00);
      cyc("p2_r3", 1'b0, 1'b0, 3'd0, 1'b1, 16'h0, 8'h08);
      chk("p2_int_lat", {15'b0, o_int}, 16'h0001);
      cyc("p2_r1", 1'b0, 1'b0, 3'd0, 1'b1, 16'h0, 8'h02);
      rd("p2_pend", 3'd0, 8'h00);
      chk("p2_pend_const", last_dat, 16'h000A);
      rd("p2_vec1", 3'd2, 8'h00);
      chk("p2_vec1_const", last_dat, 16'h8001);
      rd("p2_vec2", 3'd2, 8'h00);
      chk("p2_vec2_const", last_dat, 16'h8003);
      rd("p2_vec3", 3'd2, 8'h00);
      chk("p2_vec3_const", last_dat, 16'h0000);
      chk("p2_int_off", {15'b0, o_int}, 16'h0000);

      // Plan 3: rise coincident with W1C of the same bit - set wins
      wr("p3_w1c", 3'd0, 16'h0004, 8'h04);
      rd("p3_pend", 3'd0, 8'h00);
      chk("p3_pend_const", last_dat, 16'h0004);

      // Plan 4: software trigger while masked, then unmask
      wr("p4_en0", 3'd1, 16'h0000, 8'h00);
      wr("p4_clr", 3'd0, 16'h00FF, 8'h00);
      wr("p4_sw", 3'd3, 16'h0080, 8'h00);
      rd("p4_pend", 3'd0, 8'h00);
      chk("p4_pend_const", last_dat, 16'h0080);
      chk("p4_int_masked", {15'b0, o_int}, 16'h0000);
      wr("p4_en80", 3'd1, 16'h0080, 8'h00);
      chk("p4_int_on", {15'b0, o_int}, 16'h0001);
      rd("p4_vec", 3'd2, 8'h00);
      chk("p4_vec_const", last_dat, 16'h8007);

      // Plan 5: reset with everything pending and enabled, mid-access
      wr("p5_sw", 3'd3, 16'h00FF, 8'h00);
      wr("p5_en", 3'd1, 16'h00FF, 8'h00);
      cyc("p5_rst", 1'b1, 1'b1, 3'd3, 1'b0, 16'h00FF, 8'h00);
      chk("p5_int_const", {15'b0, o_int}, 16'h0000);
      rd("p5_pend", 3'd0, 8'h00);
      chk("p5_pend_const", last_dat, 16'h0000);
      rd("p5_en_rd", 3'd1, 8'h00);
      chk("p5_en_const", last_dat, 16'h0000);
      rd("p5_a5", 3'd5, 8'h00);
      rd("p5_a6", 3'd6, 8'h00);
      rd("p5_a7", 3'd7, 8'h00);
      chk("p5_a7_const", last_dat, 16'h0000);

      // Plan 6: level mode (or MODE reading zero when absent)
      wr("p6_mode", 3'd4, 16'h0001, 8'h00);
      rd("p6_mode_rd", 3'd4, 8'h00);
`ifdef DCPU_INTC_LEVEL_EN
      chk("p6_mode_const", last_dat, 16'h0001);
      wr("p6_en", 3'd1, 16'h0001, 8'h01);
      rd("p6_vec", 3'd2, 8'h01);
      rd("p6_pend", 3'd0, 8'h01);
      chk("p6_pend_const", last_dat, 16'h0001);
      chk("p6_int_on", {15'b0, o_int}, 16'h0001);
      cyc("p6_drop", 1'b0, 1'b0, 3'd0, 1'b1, 16'h0, 8'h00);
      chk("p6_int_off", {15'b0, o_int}, 16'h0000);
`else
      chk("p6_mode_const", last_dat, 16'h0000);
`endif

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         r  = ($urandom_range(63) == 0);
         cs = ($urandom_range(3) != 0);
         a  = 3'($urandom_range(7));
         rw = 1'($urandom_range(1));
         d  = 16'($urandom);
         s  = cur_src ^ (($urandom_range(2) == 0) ? 8'($urandom) : 8'h00);
         cyc("rnd", r, cs, a, rw, d, s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_dcpu_intc
`default_nettype wire

// File: doc/dcpu_intc.md
Name: dcpu_intc

Overview:
Memory-mapped interrupt controller that drives the dcpu `i_int` line.
- Collects up to NSRC peripheral interrupt sources, edge-detects them and latches them as pending.
- Applies a software enable mask and raises a single interrupt request to the CPU.
- The ISR at the fixed vector 0xfffa reads the VECTOR register to learn, and acknowledge, the highest-priority source.
- Sits on the CPU data bus behind an external chip-select decoder.

Parameters:
NSRC, 8, number of interrupt sources (1..15); the lowest index has the highest priority.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_src  in  NSRC  interrupt sources, synchronous to i_clk
i_cs  in  1  chip select from address decoder
i_addr  in  3  word register offset
i_rw  in  1  1=read, 0=write (dcpu o_rw convention)
i_dat  in  16  write data
o_dat  out  16  read data, combinational from i_addr; 0 when i_cs=0
o_int  out  1  interrupt request to dcpu i_int, registered

Behaviour:
Register map (offset: access, function):
- 0 PENDING: read returns pending[NSRC-1:0], zero-extended. Write is W1C: each i_dat bit =1 clears that pending bit.
- 1 ENABLE: read/write mask, bits [NSRC-1:0]; upper bits read 0.
- 2 VECTOR: read returns {valid, 11'b0, idx[3:0]}.
  - idx is the lowest set index of (pending & enable); valid = |(pending & enable).
  - Read with i_cs=1, i_rw=1 and valid=1 clears pending[idx] at that clock edge (acknowledge).
  - Read with valid=0 returns 0x0000 and has no side effect.
  - Writes are ignored.
- 3 SWSET: write sets the pending bits selected by i_dat (software trigger). Read returns 0.
- 4 MODE: see Optional Feature.
- 5..7: read 0, writes ignored.

Edge detection and pending:
- prev[i] registers i_src[i] every cycle. A rise is i_src & ~prev, and sets pending in the same clock edge.
- During reset prev loads i_src, so a source held high through reset does not trigger.
- Simultaneous set and clear of the same bit (rise or SWSET together with W1C or VECTOR ack): set wins, so no event is lost.

o_int:
- Registered: o_int <= |(pending_next & enable_next).
- Latency is 1 cycle from the source rise (or enabling write) to o_int=1.
- Deasserts the cycle after the last enabled pending bit clears.

Bus timing:
- o_dat is combinational, so a dcpu fetch-group read completes in its EXECUTE cycle.
- Register updates take effect at the edge ending the access cycle.
- Every access with i_cs=1 is one cycle; there is no wait state.

Reset:
- pending=0, enable=0, o_int=0, mode=0.
- Reset mid-access discards that access's side effects.

Optional Feature:
Macro DCPU_INTC_LEVEL_EN.
- Defined:
  - MODE register at offset 4 (read/write, bits [NSRC-1:0]). mode[i]=1 makes source i level-sensitive: pending[i] is forced to i_src[i] each cycle.
  - For a level-sensitive source, W1C and VECTOR ack have no lasting effect while the source stays high.
  - SWSET still ORs into pending for that cycle.
- Undefined: MODE reads 0, writes are ignored, all sources are edge-triggered, and no mode flops are synthesized.

Decomposition:
- Package dcpu_intc_pkg:
  - register offset constants REG_PENDING=0, REG_ENABLE=1, REG_VECTOR=2, REG_SWSET=3, REG_MODE=4
  - VECTOR_VALID_BIT=15
  - NSRC_MAX=15
- Sub-module dcpu_intc_prio: combinational priority encoder, NSRC request bits in, idx[3:0] and valid out.
- Everything else is in dcpu_intc.

Test Plan:
1. Reset with i_src=8'h01 held high, then enable=0x01 → no pending, o_int stays 0.
2. enable=0x0A; pulse i_src[3] then i_src[1] one cycle apart → PENDING=0x0A, o_int=1 one cycle after the first rise, VECTOR reads 0x8001 and clears bit 1. Next VECTOR read returns 0x8003. Third read returns 0x0000 and o_int=0.
3. Source rise on bit 2 in the same cycle as a W1C of 0x0004 → PENDING bit 2 remains 1 (set wins).
4. enable=0x00 with SWSET 0x80 → PENDING=0x80, o_int=0. Write ENABLE=0x80 → o_int=1 on the next cycle, VECTOR=0x8007.
5. Reset asserted while PENDING=0xFF and ENABLE=0xFF → next cycle PENDING=0, ENABLE=0, o_int=0. Reads to offsets 5–7 return 0.
6. With DCPU_INTC_LEVEL_EN: MODE=0x01, ENABLE=0x01, i_src[0] held high → VECTOR ack leaves PENDING bit 0 =1 and o_int=1. Drop i_src[0] → o_int=0 after 1 cycle. Without the macro, MODE reads 0x0000.
